// File: rtl/puf_auth_pkg.sv
// Shared types and defaults for the PUF signature collection / authentication stage.
package puf_auth_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam int SIG_W_DEF  = 128;
  localparam int THRESH_DEF = 12;

  // Width needed to hold a count from 0 up to and including n.
  function automatic int hd_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_hd_accum.sv
// Serial popcount: loads a difference vector, scans one bit per cycle, counts ones.
module puf_hd_accum #(
  parameter int SIG_W = 128,
  parameter int HD_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [SIG_W-1:0] i_vec,
  input  logic             i_en,
  output logic [HD_W-1:0]  o_cnt_nxt,
  output logic             o_last
);

  logic [SIG_W-1:0] r_vec;
  logic [HD_W-1:0]  r_cnt;
  logic [HD_W-1:0]  r_left;
  logic [HD_W-1:0]  w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + HD_W'(r_vec[0]);
  assign o_cnt_nxt = w_cnt_nxt;
  // High in the cycle that scans the final bit, so the caller can retire on this edge.
  assign o_last    = (r_left == HD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_vec  <= i_vec;
      r_cnt  <= '0;
      r_left <= HD_W'(SIG_W);
    end else if (i_en && (r_left != '0)) begin
      r_vec  <= r_vec >> 1;
      r_cnt  <= w_cnt_nxt;
      r_left <= r_left - HD_W'(1);
    end
  end

endmodule

// File: rtl/puf_sig_auth.sv
// Collects PUF response bits into a signature, then enrolls it as golden or
// authenticates it by serial Hamming distance against the stored golden.
module puf_sig_auth
  import puf_auth_pkg::*;
#(
  parameter int SIG_W  = SIG_W_DEF,
  parameter int HD_W   = hd_width(SIG_W_DEF),
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enroll,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [SIG_W-1:0] sig,
  output logic             golden_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [HD_W-1:0]  hd
);

  localparam int IW = $clog2(SIG_W);

  state_e           r_state, w_state_nxt;
  logic             r_mode;
  logic [IW-1:0]    r_idx;
  logic [SIG_W-1:0] r_sig, r_golden;
  logic             r_golden_valid;
  logic [HD_W-1:0]  r_hd;
  logic             r_pass;

  logic [SIG_W-1:0] w_sig_nxt;
  logic             w_idx_last;
  logic             w_acc_load;
  logic             w_acc_en;
  logic [HD_W-1:0]  w_cnt_nxt;
  logic             w_acc_last;

  // Signature including the bit being written this cycle; used both for the
  // register update and so the final bit reaches golden/compare on the same edge.
  always_comb begin
    w_sig_nxt        = r_sig;
    w_sig_nxt[r_idx] = bit_in;
  end

  assign w_idx_last = bit_valid && (r_idx == IW'(SIG_W - 1));
  assign w_acc_load = (r_state == S_COLLECT) && w_idx_last && !r_mode && r_golden_valid;
  assign w_acc_en   = (r_state == S_COMPARE);

  puf_hd_accum #(
    .SIG_W (SIG_W),
    .HD_W  (HD_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_acc_load),
    .i_vec     (w_sig_nxt ^ r_golden),
    .i_en      (w_acc_en),
    .o_cnt_nxt (w_cnt_nxt),
    .o_last    (w_acc_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_idx_last) w_state_nxt = w_acc_load ? S_COMPARE : S_DONE;
      S_COMPARE: if (w_acc_last) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode         <= 1'b0;
      r_idx          <= '0;
      r_sig          <= '0;
      r_golden       <= '0;
      r_golden_valid <= 1'b0;
      r_hd           <= '0;
      r_pass         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= enroll;
            r_sig  <= '0;
            r_idx  <= '0;
            r_hd   <= '0;
            r_pass <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (bit_valid) begin
            r_sig <= w_sig_nxt;
            r_idx <= r_idx + IW'(1);
            if (w_idx_last) begin
              if (r_mode) begin
                r_golden       <= w_sig_nxt;
                r_golden_valid <= 1'b1;
                r_hd           <= '0;
                r_pass         <= 1'b1;
              end else if (!r_golden_valid) begin
                r_hd   <= HD_W'(SIG_W);
                r_pass <= 1'b0;
              end
            end
          end
        end
        S_COMPARE: begin
          r_hd <= w_cnt_nxt;
          if (w_acc_last) r_pass <= (w_cnt_nxt <= HD_W'(THRESH));
        end
        default: ;
      endcase
    end
  end

  assign sig          = r_sig;
  assign golden_valid = r_golden_valid;
  assign busy         = (r_state == S_COLLECT) || (r_state == S_COMPARE);
  assign done         = (r_state == S_DONE);
  assign pass         = r_pass;
  assign hd           = r_hd;

endmodule

// File: tb/tb_puf_sig_auth.sv
// Directed bench for puf_sig_auth: enroll, authenticate, threshold edges, reset and protocol abuse.
module tb_puf_sig_auth;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, enroll, bit_valid, bit_in;
  logic [127:0] sig;
  logic         golden_valid, busy, done, pass;
  logic [7:0]   hd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] PAT, MASK12, MASK13, PAT_INV;

  puf_sig_auth dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .enroll       (enroll),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .sig          (sig),
    .golden_valid (golden_valid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .hd           (hd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic en);
    start  = 1'b1;
    enroll = en;
    tick();
    start  = 1'b0;
    enroll = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n, input int gapmax);
    for (int k = 0; k < n; k++) begin
      bit_valid = 1'b1;
      bit_in    = v[k];
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      if (gapmax > 0 && k < n - 1) repeat ($urandom_range(gapmax, 0)) tick();
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; enroll = 0; bit_valid = 0; bit_in = 0;
    repeat (3) tick();
    n_checks++;
    if ({sig, golden_valid, busy, done, pass, hd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: sig=%h gv=%b busy=%b done=%b pass=%b hd=%0d, want all 0",
               sig, golden_valid, busy, done, pass, hd);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_auth_no_golden();
    int lat;
    do_start(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL nogold_busy: got %b want 1", busy); end
    send_bits(PAT, 128, 0);
    wait_done(lat);
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL nogold_latency: got %0d want 0", lat); end
    n_checks++;
    if (hd !== 8'd128 || pass !== 1'b0 || golden_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nogold_result: hd=%0d pass=%b gv=%b, want hd=128 pass=0 gv=0", hd, pass, golden_valid);
    end
    tick();
  endtask

  task automatic test_enroll();
    int lat;
    do_start(1'b1);
    send_bits(PAT, 128, 5);
    wait_done(lat);
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL enroll_latency: got %0d want 0", lat); end
    n_checks++;
    if (golden_valid !== 1'b1 || hd !== 8'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL enroll_result: gv=%b hd=%0d pass=%b, want gv=1 hd=0 pass=1", golden_valid, hd, pass);
    end
    n_checks++;
    if (sig !== PAT) begin n_fail++; $display("FAIL enroll_sig: got %h want %h", sig, PAT); end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enroll_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_auth_match();
    int lat;
    do_start(1'b0);
    send_bits(PAT, 128, 0);
    // Noise on bit_valid/start while comparing must not disturb anything.
    for (int i = 0; i < 50; i++) begin
      bit_valid = 1'b1;
      bit_in    = i[0];
      start     = 1'b1;
      enroll    = 1'b1;
      tick();
    end
    bit_valid = 1'b0; start = 1'b0; enroll = 1'b0; bit_in = 1'b0;
    wait_done(lat);
    n_checks++;
    if (lat + 50 !== 128) begin n_fail++; $display("FAIL match_latency: got %0d want 128", lat + 50); end
    n_checks++;
    if (hd !== 8'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL match_result: hd=%0d pass=%b, want hd=0 pass=1", hd, pass);
    end
    n_checks++;
    if (sig !== PAT) begin n_fail++; $display("FAIL match_sig: got %h want %h", sig, PAT); end
    tick();
  endtask

  task automatic test_thresh();
    int lat;
    do_start(1'b0);
    send_bits(PAT ^ MASK12, 128, 0);
    wait_done(lat);
    n_checks++;
    if (lat !== 128) begin n_fail++; $display("FAIL hd12_latency: got %0d want 128", lat); end
    n_checks++;
    if (hd !== 8'd12 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL hd12_result: hd=%0d pass=%b, want hd=12 pass=1", hd, pass);
    end
    tick();
    do_start(1'b0);
    send_bits(PAT ^ MASK13, 128, 2);
    wait_done(lat);
    n_checks++;
    if (hd !== 8'd13 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL hd13_result: hd=%0d pass=%b, want hd=13 pass=0", hd, pass);
    end
    repeat (4) tick();
    n_checks++;
    if (hd !== 8'd13 || pass !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hd13_hold: hd=%0d pass=%b done=%b, want 13 0 0", hd, pass, done);
    end
  endtask

  task automatic test_protocol();
    int lat;
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0; bit_in = 1'b0;
    n_checks++;
    if (sig !== (PAT ^ MASK13) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bitvalid: sig=%h busy=%b, want %h 0", sig, busy, PAT ^ MASK13);
    end
    do_start(1'b0);
    send_bits(PAT, 64, 3);
    // A start with enroll mid-collection must not switch to enroll mode.
    start = 1'b1; enroll = 1'b1;
    tick();
    start = 1'b0; enroll = 1'b0;
    send_bits(PAT >> 64, 64, 3);
    wait_done(lat);
    n_checks++;
    if (lat !== 128) begin n_fail++; $display("FAIL proto_latency: got %0d want 128", lat); end
    n_checks++;
    if (sig !== PAT || hd !== 8'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_result: sig=%h hd=%0d pass=%b, want %h 0 1", sig, hd, pass, PAT);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    do_start(1'b1);
    send_bits(PAT_INV, 60, 1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sig, golden_valid, busy, done, pass, hd} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: sig=%h gv=%b busy=%b done=%b pass=%b hd=%0d, want all 0",
               sig, golden_valid, busy, done, pass, hd);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: done=%b busy=%b, want 0 0", done, busy);
    end
    do_start(1'b1);
    send_bits(PAT_INV, 128, 0);
    wait_done(lat);
    n_checks++;
    if (lat !== 0 || sig !== PAT_INV) begin
      n_fail++;
      $display("FAIL reenroll: lat=%0d sig=%h, want 0 %h", lat, sig, PAT_INV);
    end
    n_checks++;
    if (golden_valid !== 1'b1 || hd !== 8'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL reenroll_result: gv=%b hd=%0d pass=%b, want 1 0 1", golden_valid, hd, pass);
    end
    tick();
  endtask

  initial begin
    PAT     = {16{8'hA5}};
    PAT_INV = ~PAT;
    MASK12  = 128'hFFF << 40;
    MASK13  = (128'hFFF << 40) | (128'h1 << 127);
    test_reset();
    test_auth_no_golden();
    test_enroll();
    test_auth_match();
    test_thresh();
    test_protocol();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
